mmio_rr_arbiter: RTL
====================

// Module: mmio_rr_arbiter
// PURPOSE
// - Shares one AXI-lite-style 32-bit MMIO target port (ar/r/aw/w/b channels) among NUM_REQ requesters.
// - Each requester issues single-beat read/write commands on a simple cmd/rsp handshake.
// - Round-robin grant; exactly one transaction in flight on the target port at any time.
// - Sits between the host/cosim MMIO agent(s), on-chip debug agents and a register-file target.
// PARAMETERS
// NUM_REQ     2            number of requesters (>=2)
// ADDR_LIMIT  32'h2000     byte addresses >= ADDR_LIMIT are not forwarded; answered DECERR locally
// PORTS
// clk          in   1            clock
// rst          in   1            synchronous, active-high reset
// req_valid    in   NUM_REQ      per-requester command valid
// req_ready    out  NUM_REQ      per-requester command accept (one-hot or zero)
// req_write    in   NUM_REQ      1 = write, 0 = read
// req_addr     in   NUM_REQ*32   byte address, requester i at [32*i +: 32]
// req_wdata    in   NUM_REQ*32   write data, same packing
// rsp_valid    out  NUM_REQ      per-requester response valid (one-hot or zero)
// rsp_ready    in   NUM_REQ      per-requester response accept
// rsp_rdata    out  32           read data (0 for writes), shared
// rsp_resp     out  2            0 OKAY, 2 SLVERR, 3 DECERR, shared
// arvalid/arready/araddr[32]     out/in/out  target read address
// rvalid/rready/rdata[32]/rresp[2]  in/out/in/in  target read data
// awvalid/awready/awaddr[32]     out/in/out  target write address
// wvalid/wready/wdata[32]        out/in/out  target write data
// bvalid/bready/bresp[2]         in/out/in  target write response
// BEHAVIOUR
// - Reset: state IDLE, last grant = NUM_REQ-1 (so req 0 wins first), all valid/ready outputs 0, rsp_rdata/rsp_resp 0.
// - FSM: IDLE -> {RD_ADDR, WR_ADDR, RSP}; RD_ADDR -> RD_DATA -> RSP; WR_ADDR -> WR_RESP -> RSP; RSP -> IDLE.
// - IDLE: if any req_valid, pick first valid requester after last grant (wrapping); assert req_ready[g]
//   combinationally that cycle; latch g, write, addr, wdata. Exactly one req_ready bit high per accept.
// - Address check on latch: addr >= ADDR_LIMIT -> go straight to RSP with resp=3, rdata=0; no target traffic.
// - RD_ADDR: arvalid=1, araddr=latched addr; on arready -> RD_DATA.
// - RD_DATA: rready=1; on rvalid capture rdata, rresp -> RSP.
// - WR_ADDR: awvalid and wvalid both rise the first cycle; each drops after its own handshake (may occur in
//   different cycles, either order); when both done -> WR_RESP. bready=0 in WR_ADDR.
// - WR_RESP: bready=1; on bvalid capture bresp, rdata:=0 -> RSP.
// - RSP: rsp_valid[g]=1, rsp_rdata/rsp_resp stable; on rsp_ready[g] -> IDLE, last grant := g.
// - No new command accepted outside IDLE; req_ready all 0 in every other state.
// - All target-side outputs are registered; araddr/awaddr/wdata hold latched values until handshake.
// - Min latency read, ready target: accept cycle 0, ar hs cycle 1, r hs cycle 2, rsp_valid cycle 3.
// - Back-to-back: RSP handshake cycle N, next accept earliest cycle N+1 (IDLE).
// - Target responses in wrong state (rvalid in WR_*, bvalid in RD_*) are ignored; rready/bready stay 0.
// - rst mid-transaction: FSM -> IDLE next cycle, all valids deassert, in-flight result discarded.
// PACKAGE / STRUCTURE
// - mmio_arb_pkg: RESP_OKAY=2'd0, RESP_SLVERR=2'd2, RESP_DECERR=2'd3; state_t enum
//   {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, RSP}.
// - Sub-module rr_arbiter #(N): req[N], last[$clog2(N)] -> grant one-hot, grant_idx; purely combinational.
// TESTING
// - Reset, req0 read 0x10, target returns rdata=0xDEADBEEF rresp=0 -> rsp_valid[0] cycle 3, rdata 0xDEADBEEF, resp 0.
// - req0 and req1 valid continuously with reads -> grants alternate 0,1,0,1; no requester starved.
// - Write 0x18 data 0x12345678, target awready delayed 3 cycles after wready -> single aw and w handshake,
//   bready only after both, rsp resp=bresp, rdata=0.
// - Read 0x2000 (ADDR_LIMIT) -> no arvalid, rsp resp=3 within 2 cycles of accept.
// - Target returns bresp=3 for addr 0 -> rsp_resp=3 delivered to issuing requester only.
// - rst asserted while in RD_DATA -> next cycle all valids 0, state IDLE; stale rvalid later ignored.

Source files
------------

// File: rtl/mmio_arb_pkg.sv
// mmio_arb_pkg: shared response codes and FSM state encoding for the MMIO round-robin arbiter
package mmio_arb_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, RSP} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after the last grant
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);
  // scan from farthest to nearest so the nearest requester after last wins
  always_comb begin
    grant = '0;
    grant_idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last) + k) % N]) begin
        grant = '0;
        grant[(int'(last) + k) % N] = 1'b1;
        grant_idx = $clog2(N)'((int'(last) + k) % N);
      end
    end
  end
endmodule

// File: rtl/mmio_rr_arbiter.sv
// mmio_rr_arbiter: round-robin sharing of one AXI-lite MMIO target among NUM_REQ cmd/rsp requesters
module mmio_rr_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int          NUM_REQ    = 2,
  parameter logic [31:0] ADDR_LIMIT = 32'h2000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [31:0]           araddr,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [31:0]           awaddr,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [31:0]           wdata,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp
);
  localparam int GW = $clog2(NUM_REQ);
  state_t state, state_n;
  logic [GW-1:0] last, g, gi;
  logic [NUM_REQ-1:0] grant, g_hot;
  logic [31:0] addr_q, wdata_q, sel_addr;
  logic accept, sel_write, sel_dec, aw_done, w_done;
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req(req_valid),
    .last(last),
    .grant(grant),
    .grant_idx(gi)
  );
  assign sel_addr = req_addr[32*gi +: 32];
  assign sel_write = req_write[gi];
  assign sel_dec = sel_addr >= ADDR_LIMIT;
  assign accept = state == IDLE && |req_valid && !rst;
  assign req_ready = accept ? grant : '0;
  assign g_hot = NUM_REQ'(1) << g;
  assign aw_done = !awvalid || awready;
  assign w_done = !wvalid || wready;
  assign araddr = addr_q;
  assign awaddr = addr_q;
  assign wdata = wdata_q;
  // next-state: one transaction at a time, out-of-range addresses bypass the target
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (|req_valid) state_n = sel_dec ? RSP : sel_write ? WR_ADDR : RD_ADDR;
      RD_ADDR: if (arready) state_n = RD_DATA;
      RD_DATA: if (rvalid) state_n = RSP;
      WR_ADDR: if (aw_done && w_done) state_n = WR_RESP;
      WR_RESP: if (bvalid) state_n = RSP;
      RSP:     if (rsp_ready[g]) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // registered command latch, target channel handshakes and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= GW'(NUM_REQ - 1);
      g <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      arvalid <= 1'b0;
      rready <= 1'b0;
      awvalid <= 1'b0;
      wvalid <= 1'b0;
      bready <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_resp <= RESP_OKAY;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          g <= gi;
          addr_q <= sel_addr;
          wdata_q <= req_wdata[32*gi +: 32];
          arvalid <= !sel_dec && !sel_write;
          awvalid <= !sel_dec && sel_write;
          wvalid <= !sel_dec && sel_write;
          if (sel_dec) begin
            rsp_valid <= grant;
            rsp_rdata <= '0;
            rsp_resp <= RESP_DECERR;
          end
        end
        RD_ADDR: if (arready) begin
          arvalid <= 1'b0;
          rready <= 1'b1;
        end
        RD_DATA: if (rvalid) begin
          rready <= 1'b0;
          rsp_valid <= g_hot;
          rsp_rdata <= rdata;
          rsp_resp <= rresp;
        end
        WR_ADDR: begin
          if (awready) awvalid <= 1'b0;
          if (wready) wvalid <= 1'b0;
          if (aw_done && w_done) bready <= 1'b1;
        end
        WR_RESP: if (bvalid) begin
          bready <= 1'b0;
          rsp_valid <= g_hot;
          rsp_rdata <= '0;
          rsp_resp <= bresp;
        end
        RSP: if (rsp_ready[g]) begin
          rsp_valid <= '0;
          last <= g;
        end
        default: ;
      endcase
    end
  end
endmodule
